// File: rtl/aud_play_sched.sv
// ---------------------------------------------------------------------------
// aud_play_sched
//
// Playback scheduler for the I2S DAC path. Walks a mono sample buffer held in
// external memory from address 0 up to i_end_addr (inclusive), fetching one
// sample per DACLRCK frame through a req/ack read port. Each sample is
// presented on both DAC channels together with the transmitter enable.
// Supports start/pause/resume/stop, fast-forward by skipping addresses, slow
// play by repeating samples, and reports memory underrun.
//
// Optional feature (compile-time macro):
//   AUD_PLAY_LOOP_EN  - when defined, reaching the end of the buffer pulses
//                       o_done and wraps back to address 0 instead of stopping.
//
// Ports:
//   i_bclk       WM8731 bit clock, sole clock
//   i_rst_n      synchronous active-low reset
//   i_start      start from idle / resume from pause (level)
//   i_pause      pause request
//   i_stop       stop and return to idle (highest priority)
//   i_slow       0 = fast/normal address skipping, 1 = slow sample repeat
//   i_speed      rate factor N (0..7)
//   i_end_addr   last valid sample address (inclusive)
//   i_daclrck    DAC LR clock; its falling edge marks a frame
//   o_mem_req    memory read request, held until i_mem_ack
//   o_mem_addr   memory read address
//   i_mem_ack    one-cycle ack, i_mem_data valid in the same cycle
//   i_mem_data   memory read data
//   o_dac_l/r    sample presented to the transmitter (identical channels)
//   o_player_en  transmitter enable
//   o_busy       high whenever not idle
//   o_done       one-cycle pulse at end of buffer
//   o_underrun   one-cycle pulse when a frame edge finds no fetched sample
//   o_cur_addr   address of the sample currently on o_dac_*
// ---------------------------------------------------------------------------
module aud_play_sched #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_slow,
  input  logic [2:0]        i_speed,
  input  logic [ADDR_W-1:0] i_end_addr,
  input  logic              i_daclrck,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_dac_l,
  output logic [DATA_W-1:0] o_dac_r,
  output logic              o_player_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun,
  output logic [ADDR_W-1:0] o_cur_addr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          rep_q, rep_d;
  logic [DATA_W-1:0]   pend_q, pend_d;
  logic                pause_q, pause_d;
  logic                lrck_prev_q;
  logic [DATA_W-1:0]   dac_q, dac_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic                player_en_q, player_en_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;

  logic                fe;
  logic [ADDR_W:0]     adv_addr;
  logic [2:0]          adv_rep;
  logic                past_end;

  // Frame edge: falling edge of DACLRCK against the registered previous level.
  assign fe = lrck_prev_q & ~i_daclrck;

  // Candidate next address/repeat count for the current transfer. One extra
  // address bit keeps a skip past the top of memory from wrapping to a small
  // address that would compare as "not yet at the end".
  always_comb begin
    adv_addr = {1'b0, addr_q};
    adv_rep  = 3'd0;
    if (!i_slow) begin
      adv_addr = {1'b0, addr_q} + {{(ADDR_W-2){1'b0}}, i_speed} + {{ADDR_W{1'b0}}, 1'b1};
    end else if (rep_q == i_speed) begin
      adv_addr = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      adv_rep  = rep_q + 3'd1;
    end
  end

  assign past_end = (adv_addr > {1'b0, i_end_addr});

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rep_d       = rep_q;
    pend_d      = pend_q;
    pause_d     = pause_q;
    dac_d       = dac_q;
    cur_addr_d  = cur_addr_q;
    player_en_d = player_en_q;
    done_d      = 1'b0;
    underrun_d  = 1'b0;

    if (i_stop) begin
      // Stop overrides everything, including an ack in the same cycle.
      state_d     = S_IDLE;
      addr_d      = '0;
      rep_d       = '0;
      pend_d      = '0;
      pause_d     = 1'b0;
      dac_d       = '0;
      cur_addr_d  = '0;
      player_en_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          player_en_d = 1'b0;
          if (i_start) begin
            addr_d  = '0;
            rep_d   = '0;
            state_d = S_FETCH;
          end
        end

        S_FETCH: begin
          // A pause request is remembered; the fetch in flight still completes.
          if (i_pause) pause_d = 1'b1;
          // Frame edge before (or together with) the ack: nothing new to show.
          if (fe) underrun_d = 1'b1;
          if (i_mem_ack) begin
            pend_d  = i_mem_data;
            state_d = S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_pause) pause_d = 1'b1;
          if (fe) begin
            if (pause_q || i_pause) begin
              state_d     = S_PAUSE;
              player_en_d = 1'b0;
            end else begin
              dac_d       = pend_q;
              cur_addr_d  = addr_q;
              player_en_d = 1'b1;
              rep_d       = adv_rep;
              if (past_end) begin
                done_d = 1'b1;
`ifdef AUD_PLAY_LOOP_EN
                addr_d  = '0;
                rep_d   = '0;
                state_d = S_FETCH;
`else
                state_d     = S_IDLE;
                player_en_d = 1'b0;
`endif
              end else begin
                addr_d  = adv_addr[ADDR_W-1:0];
                state_d = S_FETCH;
              end
            end
          end
        end

        S_PAUSE: begin
          player_en_d = 1'b0;
          // Pause outranks start when both are requested together.
          if (i_start && !i_pause) begin
            pause_d = 1'b0;
            state_d = S_WAIT;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_bclk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rep_q       <= '0;
      pend_q      <= '0;
      pause_q     <= 1'b0;
      lrck_prev_q <= 1'b0;
      dac_q       <= '0;
      cur_addr_q  <= '0;
      player_en_q <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rep_q       <= rep_d;
      pend_q      <= pend_d;
      pause_q     <= pause_d;
      lrck_prev_q <= i_daclrck;
      dac_q       <= dac_d;
      cur_addr_q  <= cur_addr_d;
      player_en_q <= player_en_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_mem_req   = (state_q == S_FETCH);
  assign o_mem_addr  = (state_q == S_FETCH) ? addr_q : '0;
  assign o_dac_l     = dac_q;
  assign o_dac_r     = dac_q;
  assign o_player_en = player_en_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_underrun  = underrun_q;
  assign o_cur_addr  = cur_addr_q;

endmodule

// File: tb/tb_aud_play_sched.sv
// ---------------------------------------------------------------------------
// tb_aud_play_sched
//
// Directed bench for aud_play_sched. A memory model acks each request two
// cycles after it appears (returning 16'hA000 + address) unless held off, and
// DACLRCK runs with a 32-bit-clock frame. Outputs are sampled 1 time unit
// after the bit-clock edge on which a frame edge is processed.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aud_play_sched;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int FRAME  = 32;

  logic              i_bclk = 1'b0;
  logic              i_rst_n;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic              i_slow;
  logic [2:0]        i_speed;
  logic [ADDR_W-1:0] i_end_addr;
  logic              i_daclrck = 1'b1;
  logic              o_mem_req;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              i_mem_ack;
  logic [DATA_W-1:0] i_mem_data;
  logic [DATA_W-1:0] o_dac_l;
  logic [DATA_W-1:0] o_dac_r;
  logic              o_player_en;
  logic              o_busy;
  logic              o_done;
  logic              o_underrun;
  logic [ADDR_W-1:0] o_cur_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic mem_hold = 1'b0;
  int   mem_cnt  = 0;
  int   lrck_cnt = 0;

  aud_play_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_bclk      (i_bclk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_stop      (i_stop),
    .i_slow      (i_slow),
    .i_speed     (i_speed),
    .i_end_addr  (i_end_addr),
    .i_daclrck   (i_daclrck),
    .o_mem_req   (o_mem_req),
    .o_mem_addr  (o_mem_addr),
    .i_mem_ack   (i_mem_ack),
    .i_mem_data  (i_mem_data),
    .o_dac_l     (o_dac_l),
    .o_dac_r     (o_dac_r),
    .o_player_en (o_player_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_underrun  (o_underrun),
    .o_cur_addr  (o_cur_addr)
  );

  always #5 i_bclk = ~i_bclk;

  // DACLRCK: high for the first half of each frame, low for the second.
  always @(negedge i_bclk) begin
    lrck_cnt  = (lrck_cnt + 1) % FRAME;
    i_daclrck = (lrck_cnt < FRAME / 2);
  end

  // Memory model: ack two cycles after the request is seen.
  always @(negedge i_bclk) begin
    if (!mem_hold) begin
      if (o_mem_req && !i_mem_ack) begin
        mem_cnt = mem_cnt + 1;
        if (mem_cnt >= 2) begin
          i_mem_ack  = 1'b1;
          i_mem_data = 16'hA000 + o_mem_addr[15:0];
          mem_cnt    = 0;
        end
      end else begin
        i_mem_ack = 1'b0;
        mem_cnt   = 0;
      end
    end
  end

  function automatic logic [DATA_W-1:0] sample(input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    return 16'hA000 + a16;
  endfunction

  // Step to 1 time unit after the clock edge that processes the next frame edge.
  task automatic wait_fe();
    @(negedge i_daclrck);
    @(posedge i_bclk);
    #1;
  endtask

  task automatic start_play(input int end_addr, input int speed, input logic slow);
    i_end_addr = end_addr[ADDR_W-1:0];
    i_speed    = speed[2:0];
    i_slow     = slow;
    wait_fe();
    repeat (2) @(posedge i_bclk);
    #1;
    i_start = 1'b1;
    @(posedge i_bclk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    @(posedge i_bclk);
    #1;
    i_stop = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_bclk);
    #1;
    n_tests++;
    if ({o_mem_req, o_player_en, o_busy, o_done, o_underrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", {o_mem_req, o_player_en, o_busy, o_done, o_underrun});
    end
    n_tests++;
    if ({o_dac_l, o_dac_r, o_cur_addr, o_mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: dac_l=%h dac_r=%h cur=%0d maddr=%0d required all 0", o_dac_l, o_dac_r, o_cur_addr, o_mem_addr);
    end
    i_rst_n = 1'b1;
    @(posedge i_bclk);
    #1;
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_after: busy=%b required 0", o_busy);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_normal();
    start_play(3, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_fe();
      $display("[TB] normal fe%0d cur=%0d dac=%h done=%b en=%b", k, o_cur_addr, o_dac_l, o_done, o_player_en);
      n_tests++;
      if (o_cur_addr !== ADDR_W'(k) || o_dac_l !== sample(k) || o_dac_r !== sample(k)) begin
        n_fail++;
        $display("FAIL normal_sample fe%0d: cur=%0d l=%h r=%h required cur=%0d data=%h", k, o_cur_addr, o_dac_l, o_dac_r, k, sample(k));
      end
      n_tests++;
      if (o_done !== (k == 3) || o_player_en !== (k != 3) || o_busy !== (k != 3)) begin
        n_fail++;
        $display("FAIL normal_flags fe%0d: done=%b en=%b busy=%b required done=%b en=%b busy=%b", k, o_done, o_player_en, o_busy, k == 3, k != 3, k != 3);
      end
    end
    @(posedge i_bclk);
    #1;
    n_tests++;
    if (o_done !== 1'b0 || o_dac_l !== sample(3)) begin
      n_fail++;
      $display("FAIL normal_after_done: done=%b dac=%h required done=0 dac=%h", o_done, o_dac_l, sample(3));
    end
  endtask

  task automatic test_fast();
    int exp_a[4];
    exp_a = '{0, 3, 6, 9};
    start_play(10, 2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_fe();
      $display("[TB] fast fe%0d cur=%0d dac=%h done=%b", k, o_cur_addr, o_dac_l, o_done);
      n_tests++;
      if (o_cur_addr !== ADDR_W'(exp_a[k]) || o_dac_l !== sample(exp_a[k]) || o_done !== (k == 3)) begin
        n_fail++;
        $display("FAIL fast fe%0d: cur=%0d dac=%h done=%b required cur=%0d dac=%h done=%b", k, o_cur_addr, o_dac_l, o_done, exp_a[k], sample(exp_a[k]), k == 3);
      end
    end
    n_tests++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fast_idle: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_slow();
    int exp_a[4];
    exp_a = '{0, 0, 1, 1};
    start_play(1, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_fe();
      $display("[TB] slow fe%0d cur=%0d dac=%h done=%b", k, o_cur_addr, o_dac_l, o_done);
      n_tests++;
      if (o_cur_addr !== ADDR_W'(exp_a[k]) || o_dac_l !== sample(exp_a[k]) || o_done !== (k == 3)) begin
        n_fail++;
        $display("FAIL slow fe%0d: cur=%0d dac=%h done=%b required cur=%0d dac=%h done=%b", k, o_cur_addr, o_dac_l, o_done, exp_a[k], sample(exp_a[k]), k == 3);
      end
    end
  endtask

  task automatic test_underrun();
    start_play(7, 0, 1'b0);
    wait_fe();
    mem_hold = 1'b1;
    n_tests++;
    if (o_dac_l !== sample(0) || o_underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_first: dac=%h urun=%b required dac=%h urun=0", o_dac_l, o_underrun, sample(0));
    end
    for (int k = 0; k < 2; k++) begin
      wait_fe();
      $display("[TB] underrun fe%0d urun=%b dac=%h cur=%0d", k, o_underrun, o_dac_l, o_cur_addr);
      n_tests++;
      if (o_underrun !== 1'b1 || o_dac_l !== sample(0) || o_cur_addr !== '0 || o_mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL underrun_hold fe%0d: urun=%b dac=%h cur=%0d req=%b required 1 %h 0 1", k, o_underrun, o_dac_l, o_cur_addr, o_mem_req, sample(0));
      end
    end
    mem_hold = 1'b0;
    wait_fe();
    $display("[TB] underrun recover urun=%b dac=%h cur=%0d", o_underrun, o_dac_l, o_cur_addr);
    n_tests++;
    if (o_underrun !== 1'b0 || o_dac_l !== sample(1) || o_cur_addr !== ADDR_W'(1)) begin
      n_fail++;
      $display("FAIL underrun_recover: urun=%b dac=%h cur=%0d required 0 %h 1", o_underrun, o_dac_l, o_cur_addr, sample(1));
    end
    do_stop();
  endtask

  task automatic test_pause_stop();
    start_play(7, 0, 1'b0);
    wait_fe();
    repeat (6) @(posedge i_bclk);
    #1;
    i_pause = 1'b1;
    @(posedge i_bclk);
    #1;
    i_pause = 1'b0;
    wait_fe();
    $display("[TB] pause fe en=%b dac=%h cur=%0d busy=%b", o_player_en, o_dac_l, o_cur_addr, o_busy);
    n_tests++;
    if (o_player_en !== 1'b0 || o_dac_l !== sample(0) || o_cur_addr !== '0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_enter: en=%b dac=%h cur=%0d busy=%b required 0 %h 0 1", o_player_en, o_dac_l, o_cur_addr, o_busy, sample(0));
    end
    i_start = 1'b1;
    @(posedge i_bclk);
    #1;
    i_start  = 1'b0;
    mem_hold = 1'b1;
    wait_fe();
    $display("[TB] resume fe en=%b dac=%h cur=%0d", o_player_en, o_dac_l, o_cur_addr);
    n_tests++;
    if (o_player_en !== 1'b1 || o_dac_l !== sample(1) || o_cur_addr !== ADDR_W'(1)) begin
      n_fail++;
      $display("FAIL pause_resume: en=%b dac=%h cur=%0d required 1 %h 1", o_player_en, o_dac_l, o_cur_addr, sample(1));
    end
    n_tests++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== ADDR_W'(2)) begin
      n_fail++;
      $display("FAIL pause_refetch: req=%b addr=%0d required 1 2", o_mem_req, o_mem_addr);
    end
    do_stop();
    $display("[TB] stop req=%b dac=%h cur=%0d en=%b busy=%b", o_mem_req, o_dac_l, o_cur_addr, o_player_en, o_busy);
    n_tests++;
    if (o_mem_req !== 1'b0 || o_dac_l !== '0 || o_dac_r !== '0 || o_cur_addr !== '0 || o_player_en !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_clear: req=%b l=%h r=%h cur=%0d en=%b busy=%b done=%b required all 0", o_mem_req, o_dac_l, o_dac_r, o_cur_addr, o_player_en, o_busy, o_done);
    end
    i_mem_data = 16'hFFFF;
    i_mem_ack  = 1'b1;
    @(posedge i_bclk);
    #1;
    i_mem_ack = 1'b0;
    repeat (2) @(posedge i_bclk);
    #1;
    n_tests++;
    if (o_busy !== 1'b0 || o_mem_req !== 1'b0 || o_dac_l !== '0) begin
      n_fail++;
      $display("FAIL late_ack: busy=%b req=%b dac=%h required 0 0 0000", o_busy, o_mem_req, o_dac_l);
    end
    mem_hold = 1'b0;
  endtask

`ifdef AUD_PLAY_LOOP_EN
  task automatic test_loop();
    int exp_a[4];
    exp_a = '{0, 1, 0, 1};
    start_play(1, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_fe();
      $display("[TB] loop fe%0d cur=%0d dac=%h done=%b en=%b", k, o_cur_addr, o_dac_l, o_done, o_player_en);
      n_tests++;
      if (o_cur_addr !== ADDR_W'(exp_a[k]) || o_dac_l !== sample(exp_a[k]) || o_done !== (k % 2 == 1) || o_player_en !== 1'b1 || o_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL loop fe%0d: cur=%0d dac=%h done=%b en=%b busy=%b required cur=%0d done=%b en=1 busy=1", k, o_cur_addr, o_dac_l, o_done, o_player_en, o_busy, exp_a[k], k % 2 == 1);
      end
    end
    do_stop();
  endtask
`else
  task automatic test_end_zero();
    start_play(0, 0, 1'b0);
    wait_fe();
    $display("[TB] end_zero cur=%0d dac=%h done=%b busy=%b", o_cur_addr, o_dac_l, o_done, o_busy);
    n_tests++;
    if (o_cur_addr !== '0 || o_dac_l !== sample(0) || o_done !== 1'b1 || o_busy !== 1'b0 || o_player_en !== 1'b0) begin
      n_fail++;
      $display("FAIL end_zero: cur=%0d dac=%h done=%b busy=%b en=%b required 0 %h 1 0 0", o_cur_addr, o_dac_l, o_done, o_busy, o_player_en, sample(0));
    end
  endtask
`endif

  task automatic test_reset_mid();
    start_play(7, 0, 1'b0);
    wait_fe();
    wait_fe();
    n_tests++;
    if (o_dac_l !== sample(1) || o_player_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: dac=%h en=%b required %h 1", o_dac_l, o_player_en, sample(1));
    end
    i_rst_n = 1'b0;
    @(posedge i_bclk);
    #1;
    i_rst_n = 1'b1;
    $display("[TB] reset_mid req=%b dac=%h cur=%0d en=%b busy=%b", o_mem_req, o_dac_l, o_cur_addr, o_player_en, o_busy);
    n_tests++;
    if ({o_mem_req, o_player_en, o_busy, o_done, o_underrun} !== 5'b0 || o_dac_l !== '0 || o_dac_r !== '0 || o_cur_addr !== '0 || o_mem_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: req=%b en=%b busy=%b done=%b urun=%b l=%h r=%h cur=%0d required all 0", o_mem_req, o_player_en, o_busy, o_done, o_underrun, o_dac_l, o_dac_r, o_cur_addr);
    end
  endtask

  initial begin
    i_rst_n    = 1'b0;
    i_start    = 1'b0;
    i_pause    = 1'b0;
    i_stop     = 1'b0;
    i_slow     = 1'b0;
    i_speed    = 3'd0;
    i_end_addr = '0;
    i_mem_ack  = 1'b0;
    i_mem_data = '0;

    test_reset();
    test_normal();
    test_fast();
    test_slow();
    test_underrun();
    test_pause_stop();
`ifdef AUD_PLAY_LOOP_EN
    test_loop();
`else
    test_end_zero();
`endif
    test_reset_mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
